// File: rtl/riscv_pkg.sv
// Shared register-file types and widths for the writeback path.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // One pending register-file write: destination and value.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  // One-hot register mask for a destination index.
  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    return NUM_REGS'(1) << rd;
  endfunction

endpackage

// File: rtl/wb_queue.sv
// Small in-order queue of mul/div writeback results with per-entry valid bits.
// Entries can be invalidated in place by destination (kill); an invalid entry
// still occupies its slot until it reaches the head and is popped.
module wb_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_push,
  input  wb_req_t                       i_push_req,
  input  logic                          i_pop,
  input  logic                          i_kill_en,
  input  logic [REG_ADDR_W-1:0]         i_kill_rd,
  output wb_req_t                       o_head,
  output logic                          o_head_valid,
  output logic [$clog2(DEPTH+1)-1:0]    o_count,
  output logic [NUM_REGS-1:0]           o_pending_mask
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  wb_req_t          r_entry [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  // Control state: pointers, occupancy and valid bits, with kill/pop/push ordering.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; later assignments to the same bit win.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_kill_en && r_valid[i] && r_entry[i].rd == i_kill_rd) r_valid[i] <= 1'b0;
      end
      if (i_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      if (i_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  // Payload storage, written on push only.
  // NOTE: the payload array has no reset; the valid bits alone decide whether
  // an entry means anything, so clearing the data would be wasted logic.
  always_ff @(posedge clk) begin
    if (i_push) r_entry[r_tail] <= i_push_req;
  end

  assign o_head       = r_entry[r_head];
  assign o_head_valid = r_valid[r_head];
  assign o_count      = r_count;

  // Registers still owed a write by some valid queued entry.
  // NOTE: the mask gets a default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    o_pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i]) o_pending_mask = o_pending_mask | rd_onehot(r_entry[i].rd);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the in-order WB
// stage (priority) and queued mul/div results. An age counter on the queue
// head forces a one-cycle WB stall once the head has been bypassed MAX_WAIT
// times, guaranteeing forward progress.
module regfile_wb_arbiter
  import riscv_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_valid,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]       pipe_data,
  output logic                  pipe_stall,
  input  logic                  md_valid,
  input  logic [REG_ADDR_W-1:0] md_rd,
  input  logic [XLEN-1:0]       md_data,
  output logic                  md_ready,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] writereg,
  output logic [XLEN-1:0]       writedata,
  output logic [NUM_REGS-1:0]   pending_mask
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int AGE_W = $clog2(MAX_WAIT+1);

  logic [AGE_W-1:0]    r_age;
  wb_req_t             w_head;
  logic                w_head_valid;
  logic [CNT_W-1:0]    w_count;
  logic [NUM_REGS-1:0] w_mask;
  logic                w_nonempty;
  logic                w_pipe_req;
  logic                w_urgent;
  logic                w_pipe_wr;
  logic                w_head_wr;
  logic                w_head_killed;
  logic                w_pop;
  logic                w_push;

  // Inputs seen during reset are ignored, so every request is gated by !rst.
  assign w_nonempty    = (w_count != '0);
  assign w_pipe_req    = !rst && pipe_valid && (pipe_rd != '0);
  assign w_urgent      = w_head_valid && (r_age == AGE_W'(MAX_WAIT));
  assign w_pipe_wr     = w_pipe_req && !w_urgent;
  assign w_head_wr     = !rst && w_head_valid && (!w_pipe_req || w_urgent);
  // The pipe result is newer than any queued result to the same register.
  assign w_head_killed = w_pipe_wr && w_head_valid && (w_head.rd == pipe_rd);
  // Head leaves when written, killed, or already invalid (skipped).
  assign w_pop         = !rst && w_nonempty && (w_head_wr || !w_head_valid || w_head_killed);
  assign md_ready      = !rst && (w_count < CNT_W'(DEPTH));
  assign w_push        = md_valid && md_ready && (md_rd != '0);

  wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk            (clk),
    .rst            (rst),
    .i_push         (w_push),
    .i_push_req     ('{rd: md_rd, data: md_data}),
    .i_pop          (w_pop),
    .i_kill_en      (w_pipe_wr),
    .i_kill_rd      (pipe_rd),
    .o_head         (w_head),
    .o_head_valid   (w_head_valid),
    .o_count        (w_count),
    .o_pending_mask (w_mask)
  );

  // Head age: cleared on any dequeue, counts bypasses up to MAX_WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_age <= '0;
    end else if (w_pop) begin
      r_age <= '0;
    end else if (w_pipe_wr && w_head_valid && r_age != AGE_W'(MAX_WAIT)) begin
      r_age <= r_age + AGE_W'(1);
    end
  end

  assign pipe_stall   = w_pipe_req && w_urgent;
  assign RegWrite     = w_pipe_wr || w_head_wr;
  assign writereg     = w_pipe_wr ? pipe_rd   : (w_head_wr ? w_head.rd   : '0);
  assign writedata    = w_pipe_wr ? pipe_data : (w_head_wr ? w_head.data : '0);
  assign pending_mask = rst ? '0 : w_mask;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_regfile_wb_arbiter;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_valid = 1'b0;
  logic [4:0]  pipe_rd = '0;
  logic [31:0] pipe_data = '0;
  logic        pipe_stall;
  logic        md_valid = 1'b0;
  logic [4:0]  md_rd = '0;
  logic [31:0] md_data = '0;
  logic        md_ready;
  logic        RegWrite;
  logic [4:0]  writereg;
  logic [31:0] writedata;
  logic [31:0] pending_mask;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  typedef struct {
    bit        valid;
    bit [4:0]  rd;
    bit [31:0] data;
  } ent_t;

  ent_t mq[$];
  int   mage = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .pipe_valid   (pipe_valid),
    .pipe_rd      (pipe_rd),
    .pipe_data    (pipe_data),
    .pipe_stall   (pipe_stall),
    .md_valid     (md_valid),
    .md_rd        (md_rd),
    .md_data      (md_data),
    .md_ready     (md_ready),
    .RegWrite     (RegWrite),
    .writereg     (writereg),
    .writedata    (writedata),
    .pending_mask (pending_mask)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s at t=%0t: observed=0x%08h expected=0x%08h", tag, $time, obs, exp);
    end
  endtask

  // One clock cycle: drive on negedge, compare model vs DUT, advance model.
  task automatic step(input bit r, input bit pv, input bit [4:0] prd, input bit [31:0] pd,
                      input bit mv, input bit [4:0] mrd, input bit [31:0] md);
    bit        e_we, e_stall, e_ready, pipe_w, head_w, preq, hv, urg;
    bit [4:0]  e_rd;
    bit [31:0] e_data, e_mask;
    @(negedge clk);
    rst = r; pipe_valid = pv; pipe_rd = prd; pipe_data = pd;
    md_valid = mv; md_rd = mrd; md_data = md;
    #2;
    e_we = 0; e_stall = 0; e_ready = 0; e_rd = 0; e_data = 0; e_mask = 0;
    pipe_w = 0; head_w = 0;
    if (!r) begin
      preq    = pv && prd != 0;
      hv      = mq.size() > 0 && mq[0].valid;
      urg     = hv && mage == MAX_WAIT;
      e_ready = mq.size() < DEPTH;
      foreach (mq[i]) if (mq[i].valid) e_mask[mq[i].rd] = 1'b1;
      if (preq && !urg) begin
        e_we = 1; e_rd = prd; e_data = pd; pipe_w = 1;
      end else if (hv) begin
        e_we = 1; e_rd = mq[0].rd; e_data = mq[0].data; e_stall = preq; head_w = 1;
      end
    end
    check("RegWrite", RegWrite, e_we);
    check("writereg", writereg, e_rd);
    check("writedata", writedata, e_data);
    check("pipe_stall", pipe_stall, e_stall);
    check("md_ready", md_ready, e_ready);
    check("pending_mask", pending_mask, e_mask);
    if (r) begin
      mq.delete();
      mage = 0;
    end else begin
      if (pipe_w) foreach (mq[i]) if (mq[i].rd == prd) mq[i].valid = 1'b0;
      if (mq.size() > 0 && (head_w || !mq[0].valid)) begin
        void'(mq.pop_front());
        mage = 0;
      end else if (mq.size() > 0 && pipe_w && mage < MAX_WAIT) begin
        mage++;
      end
      if (mv && e_ready && mrd != 0) mq.push_back('{1'b1, mrd, md});
    end
  endtask

  initial begin
    // Reset
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 3, 32'h1, 1, 4, 32'h2);
    check("rst_we", RegWrite, 0);
    check("rst_ready", md_ready, 0);

    // Idle pipe: md result written the cycle after acceptance
    step(0, 0, 0, 0, 1, 5, 32'h1234);
    check("idle_accept", md_ready, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    check("idle_we", RegWrite, 1);
    check("idle_rd", writereg, 5);
    check("idle_data", writedata, 32'h1234);
    check("idle_mask", pending_mask, 32'h20);
    step(0, 0, 0, 0, 0, 0, 0);
    check("idle_mask_clr", pending_mask, 0);

    // Starvation guard
    step(0, 0, 0, 0, 1, 7, 32'h77);
    for (int i = 0; i < MAX_WAIT; i++) begin
      step(0, 1, 3, 32'h300 + i, 0, 0, 0);
      check("starve_pipe_rd", writereg, 3);
      check("starve_no_stall", pipe_stall, 0);
    end
    step(0, 1, 3, 32'h3ff, 0, 0, 0);
    check("starve_stall", pipe_stall, 1);
    check("starve_head_rd", writereg, 7);
    check("starve_head_data", writedata, 32'h77);
    step(0, 1, 3, 32'h3fe, 0, 0, 0);
    check("starve_resume_rd", writereg, 3);
    check("starve_resume_stall", pipe_stall, 0);

    // Full queue with busy pipe
    step(0, 1, 3, 32'h10, 1, 10, 32'hA0);
    step(0, 1, 3, 32'h11, 1, 11, 32'hB0);
    step(0, 1, 3, 32'h12, 1, 12, 32'hC0);
    check("full_not_ready", md_ready, 0);
    step(0, 1, 3, 32'h13, 1, 12, 32'hC0);
    step(0, 1, 3, 32'h14, 1, 12, 32'hC0);
    step(0, 1, 3, 32'h15, 1, 12, 32'hC0);
    check("full_urgent_stall", pipe_stall, 1);
    check("full_urgent_rd", writereg, 10);
    check("full_still_full", md_ready, 0);
    step(0, 0, 0, 0, 1, 12, 32'hC0);
    check("full_accept", md_ready, 1);
    check("full_drain_rd", writereg, 11);
    step(0, 0, 0, 0, 0, 0, 0);
    check("full_last_rd", writereg, 12);
    check("full_last_data", writedata, 32'hC0);

    // Kill: pipe result supersedes queued result to same register
    step(0, 0, 0, 0, 1, 9, 32'hAAAA);
    step(0, 1, 9, 32'hBBBB, 0, 0, 0);
    check("kill_rd", writereg, 9);
    check("kill_data", writedata, 32'hBBBB);
    check("kill_mask_held", pending_mask[9], 1);
    step(0, 0, 0, 0, 0, 0, 0);
    check("kill_no_stale_we", RegWrite, 0);
    check("kill_mask_clr", pending_mask, 0);

    // x0 handling
    step(0, 1, 3, 32'h33, 1, 6, 32'h66);
    step(0, 1, 0, 32'hDEAD, 1, 0, 32'hBEEF);
    check("x0_head_rd", writereg, 6);
    check("x0_no_stall", pipe_stall, 0);
    check("x0_md_ready", md_ready, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    check("x0_never_written", RegWrite, 0);
    check("x0_mask", pending_mask, 0);

    // Reset mid-operation with two queued entries and an md result in flight
    step(0, 1, 3, 32'h1, 1, 13, 32'hD0);
    step(0, 1, 3, 32'h2, 1, 14, 32'hE0);
    step(0, 1, 3, 32'h3, 0, 0, 0);
    check("mid_full_mask", pending_mask, 32'h6000);
    check("mid_full_ready", md_ready, 0);
    step(1, 1, 3, 32'h4, 1, 15, 32'hF0);
    check("mid_rst_ready", md_ready, 0);
    check("mid_rst_mask", pending_mask, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("mid_post_ready", md_ready, 1);
    check("mid_post_we", RegWrite, 0);
    check("mid_post_mask", pending_mask, 0);

    // Randomized traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      bit        r, pv, mv;
      bit [4:0]  prd, mrd;
      r   = ($urandom_range(0, 99) == 0);
      pv  = ($urandom_range(0, 99) < 65);
      mv  = ($urandom_range(0, 99) < 50);
      prd = 5'($urandom_range(0, 7));
      mrd = 5'($urandom_range(0, 7));
      step(r, pv, prd, $urandom, mv, mrd, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Arbitrates the single register-file write port between the in-order pipeline writeback stage and a long-latency multiply/divide unit. Long-latency results are buffered in a small queue and drained into free write slots. An age counter guarantees forward progress by stalling the pipeline writeback when a queued result has waited too long. A pending-destination mask is exported so the hazard unit can stall readers of not-yet-written registers.

## Interface
Parameters:
- DEPTH, 2: queue entries for multiply/divide results (power of two, ≥2)
- MAX_WAIT, 4: cycles a queue head may be bypassed before it becomes urgent (≥1)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- pipe_valid  in  1  WB stage has a result
- pipe_rd  in  5  WB destination register
- pipe_data  in  32  WB result
- pipe_stall  out  1  WB stage must hold its result this cycle
- md_valid  in  1  mul/div result offered
- md_rd  in  5  mul/div destination
- md_data  in  32  mul/div result
- md_ready  out  1  result accepted when md_valid && md_ready
- RegWrite  out  1  regfile write enable
- writereg  out  5  regfile write address
- writedata  out  32  regfile write data
- pending_mask  out  32  bit r set when any valid queue entry targets xr

## Operation
- A pipe request exists when pipe_valid && pipe_rd != 0. pipe_rd == 0 never uses the port and never stalls.
- A mul/div handshake with md_rd == 0 is accepted (md_ready rules apply) but not enqueued.
- md_ready = (count < DEPTH). It depends only on registered state. There is no same-cycle pass-through when full.
- urgent = queue non-empty && age == MAX_WAIT.
- Grant, evaluated each cycle:
  - Pipe request && !urgent: pipe writes. Queue head waits and age increments, saturating at MAX_WAIT.
  - Pipe request && urgent: head writes and pipe_stall = 1.
  - No pipe request && queue non-empty: head writes.
  - Otherwise RegWrite = 0.
- Kill rule: when the pipe writes rd, every valid queue entry with the same rd is invalidated in that cycle, because the pipe result is newer. A killed head is dequeued without a write, and age resets to 0.
  - Killed non-head entries stay in position as invalid and are skipped: invalid heads are popped with no write and no stall.
- age resets to 0 whenever the head is dequeued (written, killed or skipped).
- pending_mask is the OR of the one-hot rd over valid entries, from registered state.
- writereg/writedata mirror the granted source. They are 0 when RegWrite = 0.

## Timing
- Reset: count = 0, all entries invalid, age = 0.
  - While rst is high: RegWrite = 0, pipe_stall = 0, md_ready = 0, pending_mask = 0, writereg = 0, writedata = 0.
  - Inputs sampled during rst are ignored, including a mul/div result in flight, which is dropped.
- RegWrite/writereg/writedata are combinational from state and inputs in the same cycle. The regfile captures them on the following negedge.
- Pipe write latency: 0 cycles (same cycle as request, unless urgent).
- Mul/div latency: the earliest write is in the cycle after acceptance.
- Simultaneous enqueue and dequeue is allowed when count < DEPTH. count is unchanged.
- pipe_stall is held for at most 1 cycle per urgent head. After the urgent write, age = 0 for the next head.
- The queue is FIFO in acceptance order. Pointers wrap modulo DEPTH.

## Structure
- Shared package riscv_pkg:
  - XLEN = 32, REG_ADDR_W = 5, NUM_REGS = 32
  - typedef wb_req_t {rd[4:0], data[31:0]}
- One sub-module, wb_queue:
  - DEPTH-entry FIFO of wb_req_t plus valid bits
  - push/pop ports
  - kill-by-rd input
  - head/head_valid/count outputs
  - pending_mask output
- The arbiter proper holds the age counter and grant logic only.

## Test plan
- Reset mid-operation: queue holding 2 entries, assert rst 1 cycle → count = 0, pending_mask = 0, md_ready = 0 during reset and 1 the cycle after.
- Idle pipe: md accepts rd = 5, data = 0x1234 at cycle N → RegWrite = 1, writereg = 5, writedata = 0x1234 at N+1; pending_mask[5] is set during N+1 only.
- Starvation guard: queue head rd = 7, pipe requests rd = 3 every cycle with MAX_WAIT = 4 → pipe writes 4 cycles, then x7 is written with pipe_stall = 1 in cycle 5, then the pipe resumes.
- Full queue: DEPTH = 2 full and pipe busy → md_ready = 0; md_valid is held and accepted the cycle after the first dequeue.
- Kill: queue holds rd = 9 (data A) and the pipe writes rd = 9 (data B) → the queue entry is dropped, x9 receives only B, and pending_mask[9] clears the next cycle.
- x0: pipe_rd = 0 with a queue head pending → head written the same cycle with pipe_stall = 0; md_rd = 0 accepted, never written, count unchanged.
